planes_cache_pn: RTL and testbench

Parametrised, double-buffered successor to the two-row plane cache in the GPU display path. It holds one active plane of `ROWS` scan rows × `WIDTH` columns of 1-bit R/G/B data and shifts it out one column per `in_SHIFT`. A second staging bank is loaded row-by-row while the active bank is being shifted. The banks exchange on an explicit swap, or automatically at end of row when `AUTO_SWAP=1`. It sits between the plane fetch logic and the matrix output driver.

---
 rtl/planes_cache_pn.sv | 130 +++++++++++++
 tb/tb_planes_cache_pn.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/planes_cache_pn.sv
// Double-buffered R/G/B plane cache: a staging bank is loaded row by row while the
// active bank shifts one column per SHIFT toward the matrix output driver.
module planes_cache_pn #(
  parameter int WIDTH     = 64,
  parameter int ROWS      = 2,
  parameter int AUTO_SWAP = 0,
  localparam int RSW      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW       = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_R,
  input  logic [WIDTH-1:0]  in_G,
  input  logic [WIDTH-1:0]  in_B,
  input  logic [RSW-1:0]    in_row_sel,
  input  logic              in_LOAD,
  input  logic              in_SWAP,
  input  logic              in_SHIFT,
  output logic [3*ROWS-1:0] out_RGB,
  output logic [CW-1:0]     out_col,
  output logic              out_last,
  output logic              out_empty,
  output logic              out_stage_full,
  output logic              out_err
);

  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
  localparam logic [RSW:0]  ROWS_W   = (RSW + 1)'(ROWS);

  logic [WIDTH-1:0] act_r [ROWS];
  logic [WIDTH-1:0] act_g [ROWS];
  logic [WIDTH-1:0] act_b [ROWS];
  logic [WIDTH-1:0] stg_r [ROWS];
  logic [WIDTH-1:0] stg_g [ROWS];
  logic [WIDTH-1:0] stg_b [ROWS];
  logic [ROWS-1:0]  stg_valid;
  logic [ROWS-1:0]  stg_valid_next;
  logic             act_valid;
  logic [CW-1:0]    col;
  logic             err;

  logic stage_full, sel_ok, load_ok, at_last;
  logic swap_man, swap_auto, do_swap, shift_ok, row_end, err_next;

  assign stage_full = &stg_valid;
  assign sel_ok     = ({1'b0, in_row_sel} < ROWS_W);
  assign load_ok    = in_LOAD && sel_ok;
  assign at_last    = (col == LAST_COL);

  // An accepted explicit swap takes priority and silently drops a same-cycle shift.
  assign swap_man   = in_SWAP && stage_full;
  assign shift_ok   = in_SHIFT && act_valid && !swap_man;
  assign swap_auto  = (AUTO_SWAP != 0) && shift_ok && at_last && stage_full;
  assign do_swap    = swap_man || swap_auto;
  assign row_end    = shift_ok && at_last && !swap_auto;
  assign err_next   = (in_SWAP && !stage_full)
                   || (in_SHIFT && !act_valid && !swap_man)
                   || (in_LOAD && !sel_ok);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    stg_valid_next = do_swap ? '0 : stg_valid;
    if (load_ok) stg_valid_next[in_row_sel] = 1'b1;
  end

  // NOTE: the banks are reset too, because a cleared plane must drive zeros on out_RGB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        act_r[r] <= '0;
        act_g[r] <= '0;
        act_b[r] <= '0;
        stg_r[r] <= '0;
        stg_g[r] <= '0;
        stg_b[r] <= '0;
      end
      stg_valid <= '0;
      act_valid <= 1'b0;
      col       <= '0;
      err       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so every read below sees pre-edge state.
      err       <= err_next;
      stg_valid <= stg_valid_next;
      if (do_swap) begin
        for (int r = 0; r < ROWS; r++) begin
          act_r[r] <= stg_r[r];
          act_g[r] <= stg_g[r];
          act_b[r] <= stg_b[r];
        end
        act_valid <= 1'b1;
        col       <= '0;
      end else if (row_end) begin
        for (int r = 0; r < ROWS; r++) begin
          act_r[r] <= '0;
          act_g[r] <= '0;
          act_b[r] <= '0;
        end
        act_valid <= 1'b0;
        col       <= '0;
      end else if (shift_ok) begin
        for (int r = 0; r < ROWS; r++) begin
          act_r[r] <= {act_r[r][WIDTH-2:0], 1'b0};
          act_g[r] <= {act_g[r][WIDTH-2:0], 1'b0};
          act_b[r] <= {act_b[r][WIDTH-2:0], 1'b0};
        end
        col <= col + 1'b1;
      end
      // Swap reads the old staging contents; a same-cycle load lands in the cleared staging.
      if (load_ok) begin
        stg_r[in_row_sel] <= in_R;
        stg_g[in_row_sel] <= in_G;
        stg_b[in_row_sel] <= in_B;
      end
    end
  end

  always_comb begin
    out_RGB = '0;
    for (int r = 0; r < ROWS; r++)
      out_RGB[3*(ROWS-1-r) +: 3] = {act_r[r][WIDTH-1], act_g[r][WIDTH-1], act_b[r][WIDTH-1]};
  end

  assign out_col        = col;
  assign out_last       = act_valid && at_last;
  assign out_empty      = !act_valid;
  assign out_stage_full = stage_full;
  assign out_err        = err;

endmodule

// File: tb/tb_planes_cache_pn.sv
// Scoreboard bench for planes_cache_pn: directed steps push expected outputs,
// a negedge monitor pops and compares against the selected DUT instance.
module tb_planes_cache_pn;

  typedef struct packed {
    int         id;
    logic [5:0] rgb;
    logic [5:0] col;
    logic       last;
    logic       empty;
    logic       full;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_d;
  logic [0:0]  in_row_sel;
  logic        in_LOAD, in_SWAP, in_SHIFT;
  logic        sel_auto;

  logic [5:0] rgb0, rgb1, col0, col1;
  logic       last0, last1, empty0, empty1, full0, full1, err0, err1;

  int total = 0;
  int bad   = 0;
  int step_id = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  planes_cache_pn #(.WIDTH(64), .ROWS(2), .AUTO_SWAP(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_R(in_d), .in_G(in_d), .in_B(in_d),
    .in_row_sel(in_row_sel), .in_LOAD(in_LOAD), .in_SWAP(in_SWAP), .in_SHIFT(in_SHIFT),
    .out_RGB(rgb0), .out_col(col0), .out_last(last0), .out_empty(empty0),
    .out_stage_full(full0), .out_err(err0)
  );

  planes_cache_pn #(.WIDTH(64), .ROWS(2), .AUTO_SWAP(1)) u_dut_auto (
    .clk(clk), .rst_n(rst_n), .in_R(in_d), .in_G(in_d), .in_B(in_d),
    .in_row_sel(in_row_sel), .in_LOAD(in_LOAD), .in_SWAP(in_SWAP), .in_SHIFT(in_SHIFT),
    .out_RGB(rgb1), .out_col(col1), .out_last(last1), .out_empty(empty1),
    .out_stage_full(full1), .out_err(err1)
  );

  logic [5:0] s_rgb, s_col;
  logic       s_last, s_empty, s_full, s_err;
  assign s_rgb   = sel_auto ? rgb1   : rgb0;
  assign s_col   = sel_auto ? col1   : col0;
  assign s_last  = sel_auto ? last1  : last0;
  assign s_empty = sel_auto ? empty1 : empty0;
  assign s_full  = sel_auto ? full1  : full0;
  assign s_err   = sel_auto ? err1   : err0;

  task automatic check(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", name, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("rgb",   e.id, 64'(s_rgb),   64'(e.rgb));
      check("col",   e.id, 64'(s_col),   64'(e.col));
      check("last",  e.id, 64'(s_last),  64'(e.last));
      check("empty", e.id, 64'(s_empty), 64'(e.empty));
      check("full",  e.id, 64'(s_full),  64'(e.full));
      check("err",   e.id, 64'(s_err),   64'(e.err));
    end
  end

  function automatic exp_t mk(input logic [5:0] rgb, input int col, input logic last,
                              input logic empty, input logic full, input logic err);
    exp_t e;
    e.id = 0; e.rgb = rgb; e.col = 6'(col); e.last = last;
    e.empty = empty; e.full = full; e.err = err;
    return e;
  endfunction

  // Column c of a row is bit 63-c of the loaded word.
  function automatic logic [5:0] col_rgb(input logic [63:0] a, input logic [63:0] b, input int c);
    return {{3{a[63-c]}}, {3{b[63-c]}}};
  endfunction

  task automatic step(input logic ld, input logic sel, input logic [63:0] d,
                      input logic sw, input logic sh, input exp_t e);
    @(negedge clk);
    #1;
    in_LOAD = ld; in_row_sel = sel; in_d = d; in_SWAP = sw; in_SHIFT = sh;
    e.id = step_id++;
    q.push_back(e);
  endtask

  task automatic check_reset(input string name);
    check({name, "_rgb"},   -1, 64'(s_rgb),   64'd0);
    check({name, "_col"},   -1, 64'(s_col),   64'd0);
    check({name, "_last"},  -1, 64'(s_last),  64'd0);
    check({name, "_empty"}, -1, 64'(s_empty), 64'd1);
    check({name, "_full"},  -1, 64'(s_full),  64'd0);
    check({name, "_err"},   -1, 64'(s_err),   64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r0, r1, ones, fives, top;
    logic [5:0]  e_rgb;
    logic        e_full;
    int          c;
    r0    = 64'h0123ABCD;
    r1    = 64'hDCBA3210;
    ones  = '1;
    fives = 64'h5555_5555_5555_5555;
    top   = 64'h8000_0000_0000_0000;

    sel_auto = 1'b0;
    rst_n = 1'b0;
    in_d = '0; in_row_sel = '0; in_LOAD = 0; in_SWAP = 0; in_SHIFT = 0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    #1 rst_n = 1'b1;

    // Basic plane: load both rows, swap, shift a full row out
    step(0, 0, 0,  0, 0, mk(6'b000000, 0, 0, 1, 0, 0));
    step(1, 0, r0, 0, 0, mk(6'b000000, 0, 0, 1, 0, 0));
    step(1, 1, r1, 0, 0, mk(6'b000000, 0, 0, 1, 1, 0));
    step(0, 0, 0,  1, 0, mk(6'b000000, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 63; i++) begin
      e_rgb = (i == 32) ? 6'b000111 : (i == 39) ? 6'b111000 : col_rgb(r0, r1, i);
      step(0, 0, 0, 0, 1, mk(e_rgb, i, i == 63, 0, 0, 0));
    end
    step(0, 0, 0, 0, 1, mk(6'b000000, 0, 0, 1, 0, 0));   // 64th shift empties
    step(0, 0, 0, 0, 1, mk(6'b000000, 0, 0, 1, 0, 1));   // shift while empty
    step(0, 0, 0, 0, 0, mk(6'b000000, 0, 0, 1, 0, 0));

    // Swap with only row0 loaded is rejected
    step(1, 0, r0, 0, 0, mk(6'b000000, 0, 0, 1, 0, 0));
    step(0, 0, 0,  1, 0, mk(6'b000000, 0, 0, 1, 0, 1));
    step(0, 0, 0,  0, 0, mk(6'b000000, 0, 0, 1, 0, 0));

    // SWAP+LOAD: active gets old staging, only the loaded row stays valid
    step(1, 1, top,  0, 0, mk(6'b000000, 0, 0, 1, 1, 0));
    step(1, 1, ones, 1, 0, mk(6'b000111, 0, 0, 0, 0, 0));
    step(1, 0, ones, 0, 0, mk(6'b000111, 0, 0, 0, 1, 0));
    // SWAP+SHIFT: swap wins, no error
    step(0, 0, 0, 1, 1, mk(6'b111111, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 10; i++)
      step(0, 0, 0, 0, 1, mk(6'b111111, i, 0, 0, 0, 0));

    // Asynchronous reset mid-row (col 10), observed before the next clock edge
    @(negedge clk);
    #1;
    in_LOAD = 0; in_SWAP = 0; in_SHIFT = 0; in_d = '0;
    check("pre_rst_col", -1, 64'(s_col), 64'd10);
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Auto-swap instance: back-to-back rows with no bubble
    sel_auto = 1'b1;
    step(1, 0, ones,  0, 0, mk(6'b000000, 0, 0, 1, 0, 0));
    step(1, 1, ones,  0, 0, mk(6'b000000, 0, 0, 1, 1, 0));
    step(0, 0, 0,     1, 0, mk(6'b111111, 0, 0, 0, 0, 0));
    step(1, 0, fives, 0, 0, mk(6'b111111, 0, 0, 0, 0, 0));
    step(1, 1, fives, 0, 0, mk(6'b111111, 0, 0, 0, 1, 0));
    for (int i = 1; i <= 128; i++) begin
      c = i % 64;
      if (i < 64)       e_rgb = 6'b111111;
      else if (i < 128) e_rgb = c[0] ? 6'b111111 : 6'b000000;
      else              e_rgb = 6'b111111;
      e_full = (i < 64) || (i >= 71 && i < 128);
      if (i == 70)      step(1, 0, ones, 0, 1, mk(e_rgb, c, c == 63, 0, e_full, 0));
      else if (i == 71) step(1, 1, ones, 0, 1, mk(e_rgb, c, c == 63, 0, e_full, 0));
      else              step(0, 0, 0,    0, 1, mk(e_rgb, c, c == 63, 0, e_full, 0));
    end
    @(negedge clk);
    #1;
    in_LOAD = 0; in_SWAP = 0; in_SHIFT = 0;

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    if (q.size() != 0) check("drain", -1, 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
